mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between instruction fetch (I port) and the MEM stage (D port).
//  Data requests have fixed priority; a starvation guard forces an I grant after STARVE_LIMIT consecutive D wins.
//  Exactly one access is issued per cycle; the read response returns on the following cycle.
//  Sits between the fetcher/MEM stage and the Memory instance. Drives stall_if / stall_mem to the hazard logic.
// PARAMETERS
//  ADDR_W        32  address width (addr_t)
//  DATA_W        32  data width (op_t / inst_t)
//  STARVE_LIMIT  4   consecutive D grants, with I waiting, before I is forced; must be >= 1
// PORTS
//  clk           in   1       clock; all state updates on posedge
//  rst           in   1       synchronous reset, active-high
//  i_req_valid   in   1       fetch request pending
//  i_req_ready   out  1       fetch request granted this cycle
//  i_addr        in   ADDR_W  fetch address
//  i_resp_valid  out  1       fetch data valid (cycle after grant)
//  i_resp_data   out  DATA_W  fetched instruction
//  d_req_valid   in   1       data request pending
//  d_req_ready   out  1       data request granted this cycle
//  d_addr        in   ADDR_W  data address
//  d_we          in   1       1 = store, 0 = load
//  d_wdata       in   DATA_W  store data
//  d_resp_valid  out  1       load data / store ack valid (cycle after grant)
//  d_resp_data   out  DATA_W  load data; 0 for store ack
//  mem_addr      out  ADDR_W  memory address
//  mem_we        out  1       memory write enable
//  mem_wdata     out  DATA_W  memory write data
//  mem_rdata     in   DATA_W  memory read data, valid 1 cycle after address
//  stall_if      out  1       i_req_valid & ~i_req_ready
//  stall_mem     out  1       d_req_valid & ~d_req_ready
// BEHAVIOUR
//  - Reset: state=IDLE, starve_cnt=0; all *_ready, *_resp_valid, mem_we, stall_* = 0.
//    mem_addr, mem_wdata and *_resp_data = 0. rst dominates the same-cycle combinational grant.
//  - Arbitration every cycle, in every state, is combinational and uses the current valids:
//    - Both valid: D wins, unless starve_cnt==STARVE_LIMIT, in which case I wins.
//    - One valid: that port wins.
//    - Neither valid: no grant, mem_we=0.
//  - Grant cycle N:
//    - winner's ready=1; mem_addr = winner addr.
//    - mem_we = d_we & D-grant; mem_wdata = d_wdata.
//    - Requester must hold valid/addr/data stable until ready.
//  - FSM next state: RESP_I on I grant, RESP_D on D grant (read or write), IDLE on no grant.
//  - Cycle N+1:
//    - RESP_I: i_resp_valid=1, i_resp_data=mem_rdata.
//    - RESP_D: d_resp_valid=1, d_resp_data = (registered we ? 0 : mem_rdata).
//  - Throughput: a new grant can occur in the same cycle as the previous response (1 access/cycle).
//  - Load latency: 1 cycle. A store commits at the posedge ending cycle N; a load granted at N+1 to the same address returns new data.
//  - starve_cnt:
//    - +1 (saturating at STARVE_LIMIT) on a D grant while i_req_valid=1.
//    - Cleared on an I grant or when i_req_valid=0.
//  - Reset mid-operation: any pending response is dropped (no resp_valid after rst); the counter is cleared.
//  - Responses carry no ID. Ordering is guaranteed by a single outstanding access.
// STRUCTURE
//  - Package MemArbType:
//    - arb_state_t enum {IDLE, RESP_I, RESP_D}
//    - arb_grant_t enum {GRANT_NONE, GRANT_I, GRANT_D}
//    - localparam STARVE_W = $clog2(STARVE_LIMIT+1) derived in the module.
//  - Sub-module arb_starve_counter (inputs clk, rst, inc, clr; output at_limit) isolates the saturating counter.
//  - Top holds the grant mux, FSM and response register (resp_is_write).
// TESTING
//  1. I only: i_addr=0x10 (mem[0x10]=0xAAAA) for 3 cycles -> i_req_ready=1 each cycle; i_resp_data=0xAAAA on cycles 2..4; stall_if=0.
//  2. Conflict: I and D loads valid together, STARVE_LIMIT=4 -> D granted 4 cycles (stall_if=1); cycle 5 grants I; counter clears.
//  3. Store then load: D write 0x20<=0x1234, next cycle D read 0x20 -> d_resp_data=0 (ack), then 0x1234; mem_we high exactly 1 cycle.
//  4. D load granted, rst asserted next cycle -> d_resp_valid=0 during and after rst; no outputs high until new request.
//  5. Alternating d_req_valid (1,0,1,0) with I held -> counter never reaches limit; I granted on every D-idle cycle.
//  6. Idle: no valids for 5 cycles -> mem_we=0, all resp_valid=0, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the I/D memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF       = 32;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  // Response slot owner for the cycle after a grant
  typedef enum logic [1:0] {
    IDLE,
    RESP_I,
    RESP_D
  } arb_state_t;

  // Combinational winner of the current cycle
  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_I,
    GRANT_D
  } arb_grant_t;

  // Response slot that follows a given grant
  function automatic arb_state_t resp_state(arb_grant_t g);
    arb_state_t s;
    s = IDLE;
    case (g)
      GRANT_I: s = RESP_I;
      GRANT_D: s = RESP_D;
      default: s = IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive D wins while fetch is waiting.
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned STARVE_W = $clog2(LIMIT + 1);

  logic [STARVE_W-1:0] cnt_q;

  // Clear wins over increment; hold once the limit is reached
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != STARVE_W'(LIMIT))) begin
      cnt_q <= cnt_q + STARVE_W'(1);
    end
  end

  assign at_limit = (cnt_q == STARVE_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch (I) and MEM stage (D).
// D has priority; fetch is forced through after STARVE_LIMIT consecutive D wins.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  arb_state_t state_q, state_d;
  arb_grant_t grant;
  logic       resp_is_write_q, resp_is_write_d;
  logic       at_limit;
  logic       cnt_inc, cnt_clr;

  // Winner of this cycle; reset suppresses any grant
  always_comb begin
    grant = GRANT_NONE;
    if (!rst) begin
      if (i_req_valid && d_req_valid) begin
        grant = at_limit ? GRANT_I : GRANT_D;
      end else if (i_req_valid) begin
        grant = GRANT_I;
      end else if (d_req_valid) begin
        grant = GRANT_D;
      end
    end
  end

  assign cnt_inc = (grant == GRANT_D) && i_req_valid;
  assign cnt_clr = (grant == GRANT_I) || !i_req_valid;

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc     (cnt_inc),
    .clr     (cnt_clr),
    .at_limit(at_limit)
  );

  // Response slot register: who gets the read data next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      resp_is_write_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      resp_is_write_q <= resp_is_write_d;
    end
  end

  // Grant mux, next response slot and response steering
  always_comb begin
    state_d         = resp_state(grant);
    resp_is_write_d = 1'b0;
    i_req_ready     = 1'b0;
    d_req_ready     = 1'b0;
    mem_addr        = '0;
    mem_we          = 1'b0;
    mem_wdata       = '0;
    i_resp_valid    = 1'b0;
    i_resp_data     = '0;
    d_resp_valid    = 1'b0;
    d_resp_data     = '0;

    case (grant)
      GRANT_I: begin
        i_req_ready = 1'b1;
        mem_addr    = i_addr;
      end
      GRANT_D: begin
        d_req_ready     = 1'b1;
        mem_addr        = d_addr;
        mem_we          = d_we;
        resp_is_write_d = d_we;
      end
      default: ;
    endcase

    if (!rst) begin
      mem_wdata = d_wdata;
      case (state_q)
        RESP_I: begin
          i_resp_valid = 1'b1;
          i_resp_data  = mem_rdata;
        end
        RESP_D: begin
          d_resp_valid = 1'b1;
          d_resp_data  = resp_is_write_q ? '0 : mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign stall_if  = !rst && i_req_valid && (grant != GRANT_I);
  assign stall_mem = !rst && d_req_valid && (grant != GRANT_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed table plus constrained-random traffic vs. a reference model.
module tb_mem_port_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_ready, i_resp_valid;
  logic [31:0] i_addr, i_resp_data;
  logic        d_req_valid, d_req_ready, d_we, d_resp_valid;
  logic [31:0] d_addr, d_wdata, d_resp_data;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, stall_if, stall_mem;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_we(d_we), .d_wdata(d_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  // Environment memory: synchronous single port, read data one cycle after address
  logic [31:0] env_mem [64];
  always @(posedge clk) begin
    if (mem_we) env_mem[mem_addr[5:0]] <= mem_wdata;
    mem_rdata <= env_mem[mem_addr[5:0]];
  end

  // Reference model state
  logic [31:0] ref_mem [64];
  int          ref_cnt;
  int          pend;       // 0 none, 1 fetch response due, 2 data response due
  logic [31:0] pend_data;

  typedef struct {
    logic rst; logic iv; logic [31:0] ia;
    logic dv; logic [31:0] da; logic we; logic [31:0] wd;
    logic eir; logic edr; logic ewe;
    logic eirv; logic [31:0] eird; logic edrv; logic [31:0] edrd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic r, logic iv, logic [31:0] ia, logic dv, logic [31:0] da,
                               logic we, logic [31:0] wd, logic eir, logic edr, logic ewe,
                               logic eirv, logic [31:0] eird, logic edrv, logic [31:0] edrd);
    vec_t v;
    v.rst = r; v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.we = we; v.wd = wd;
    v.eir = eir; v.edr = edr; v.ewe = ewe;
    v.eirv = eirv; v.eird = eird; v.edrv = edrv; v.edrd = edrd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive, check against model (and table if use_exp), then advance model
  task automatic run_cycle(input vec_t t, input bit use_exp, output bit gi, output bit gd);
    logic [31:0] e_addr;
    bit e_irv, e_drv;
    @(negedge clk);
    rst = t.rst; i_req_valid = t.iv; i_addr = t.ia;
    d_req_valid = t.dv; d_addr = t.da; d_we = t.we; d_wdata = t.wd;
    gi = 1'b0; gd = 1'b0;
    if (!t.rst) begin
      if (t.iv && t.dv) begin
        if (ref_cnt == LIMIT) gi = 1'b1; else gd = 1'b1;
      end else if (t.iv) gi = 1'b1;
      else if (t.dv) gd = 1'b1;
    end
    e_addr = gi ? t.ia : (gd ? t.da : 32'h0);
    e_irv  = !t.rst && (pend == 1);
    e_drv  = !t.rst && (pend == 2);
    #1;
    chk("i_req_ready", i_req_ready, gi);
    chk("d_req_ready", d_req_ready, gd);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_we", mem_we, gd && t.we);
    chk("mem_wdata", mem_wdata, t.rst ? 32'h0 : t.wd);
    chk("stall_if", stall_if, !t.rst && t.iv && !gi);
    chk("stall_mem", stall_mem, !t.rst && t.dv && !gd);
    chk("i_resp_valid", i_resp_valid, e_irv);
    chk("i_resp_data", i_resp_data, e_irv ? pend_data : 32'h0);
    chk("d_resp_valid", d_resp_valid, e_drv);
    chk("d_resp_data", d_resp_data, e_drv ? pend_data : 32'h0);
    if (use_exp) begin
      chk("tbl_i_req_ready", i_req_ready, t.eir);
      chk("tbl_d_req_ready", d_req_ready, t.edr);
      chk("tbl_mem_we", mem_we, t.ewe);
      chk("tbl_i_resp_valid", i_resp_valid, t.eirv);
      if (t.eirv) chk("tbl_i_resp_data", i_resp_data, t.eird);
      chk("tbl_d_resp_valid", d_resp_valid, t.edrv);
      if (t.edrv) chk("tbl_d_resp_data", d_resp_data, t.edrd);
    end
    @(posedge clk);
    if (t.rst) begin
      ref_cnt = 0;
      pend    = 0;
    end else begin
      pend = 0;
      if (gi) begin
        pend      = 1;
        pend_data = ref_mem[t.ia[5:0]];
      end else if (gd) begin
        pend      = 2;
        pend_data = t.we ? 32'h0 : ref_mem[t.da[5:0]];
        if (t.we) ref_mem[t.da[5:0]] = t.wd;
      end
      if (gi || !t.iv) ref_cnt = 0;
      else if (gd && ref_cnt < LIMIT) ref_cnt = ref_cnt + 1;
    end
  endtask

  initial begin
    bit gi, gd, i_hold, d_hold;
    vec_t r;
    rst = 1'b1; i_req_valid = 1'b0; i_addr = '0; d_req_valid = 1'b0;
    d_addr = '0; d_we = 1'b0; d_wdata = '0;
    ref_cnt = 0; pend = 0; pend_data = '0;
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = 32'hdead_0000 ^ (32'(i) * 32'h0101_0101);
      ref_mem[i] = env_mem[i];
    end
    env_mem[16] = 32'h0000_AAAA; ref_mem[16] = 32'h0000_AAAA;
    env_mem[17] = 32'h0000_5555; ref_mem[17] = 32'h0000_5555;

    //             rst iv ia     dv da     we wd        ir dr we irv ird    drv drd
    tbl.push_back(mkv(1, 0, 0,     0, 0,     0, 0,        0, 0, 0, 0, 0,      0, 0));
    // fetch only, back to back
    tbl.push_back(mkv(0, 1, 'h10,  0, 0,     0, 0,        1, 0, 0, 0, 0,      0, 0));
    tbl.push_back(mkv(0, 1, 'h10,  0, 0,     0, 0,        1, 0, 0, 1, 'hAAAA, 0, 0));
    tbl.push_back(mkv(0, 1, 'h10,  0, 0,     0, 0,        1, 0, 0, 1, 'hAAAA, 0, 0));
    tbl.push_back(mkv(0, 0, 0,     0, 0,     0, 0,        0, 0, 0, 1, 'hAAAA, 0, 0));
    // conflict: four D wins then a forced I grant, then D again
    tbl.push_back(mkv(0, 1, 'h10,  1, 'h11,  0, 0,        0, 1, 0, 0, 0,      0, 0));
    tbl.push_back(mkv(0, 1, 'h10,  1, 'h11,  0, 0,        0, 1, 0, 0, 0,      1, 'h5555));
    tbl.push_back(mkv(0, 1, 'h10,  1, 'h11,  0, 0,        0, 1, 0, 0, 0,      1, 'h5555));
    tbl.push_back(mkv(0, 1, 'h10,  1, 'h11,  0, 0,        0, 1, 0, 0, 0,      1, 'h5555));
    tbl.push_back(mkv(0, 1, 'h10,  1, 'h11,  0, 0,        1, 0, 0, 0, 0,      1, 'h5555));
    tbl.push_back(mkv(0, 1, 'h10,  1, 'h11,  0, 0,        0, 1, 0, 1, 'hAAAA, 0, 0));
    tbl.push_back(mkv(0, 0, 0,     0, 0,     0, 0,        0, 0, 0, 0, 0,      1, 'h5555));
    // store then load same address
    tbl.push_back(mkv(0, 0, 0,     1, 'h20,  1, 'h1234,   0, 1, 1, 0, 0,      0, 0));
    tbl.push_back(mkv(0, 0, 0,     1, 'h20,  0, 0,        0, 1, 0, 0, 0,      1, 0));
    tbl.push_back(mkv(0, 0, 0,     0, 0,     0, 0,        0, 0, 0, 0, 0,      1, 'h1234));
    // load granted, reset next cycle drops the response
    tbl.push_back(mkv(0, 0, 0,     1, 'h11,  0, 0,        0, 1, 0, 0, 0,      0, 0));
    tbl.push_back(mkv(1, 0, 0,     1, 'h11,  0, 0,        0, 0, 0, 0, 0,      0, 0));
    tbl.push_back(mkv(0, 0, 0,     0, 0,     0, 0,        0, 0, 0, 0, 0,      0, 0));
    tbl.push_back(mkv(0, 0, 0,     0, 0,     0, 0,        0, 0, 0, 0, 0,      0, 0));
    // alternating D with fetch held
    tbl.push_back(mkv(0, 1, 'h10,  1, 'h11,  0, 0,        0, 1, 0, 0, 0,      0, 0));
    tbl.push_back(mkv(0, 1, 'h10,  0, 0,     0, 0,        1, 0, 0, 0, 0,      1, 'h5555));
    tbl.push_back(mkv(0, 1, 'h10,  1, 'h11,  0, 0,        0, 1, 0, 1, 'hAAAA, 0, 0));
    tbl.push_back(mkv(0, 1, 'h10,  0, 0,     0, 0,        1, 0, 0, 0, 0,      1, 'h5555));
    tbl.push_back(mkv(0, 0, 0,     0, 0,     0, 0,        0, 0, 0, 1, 'hAAAA, 0, 0));
    // idle
    for (int k = 0; k < 5; k++)
      tbl.push_back(mkv(0, 0, 0,   0, 0,     0, 0,        0, 0, 0, 0, 0,      0, 0));

    foreach (tbl[k]) run_cycle(tbl[k], 1'b1, gi, gd);

    // Random traffic; an ungranted requester holds its request until accepted
    i_hold = 1'b0; d_hold = 1'b0;
    r = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      r.rst = ($urandom_range(0, 59) == 0);
      if (!i_hold) begin
        r.iv = ($urandom_range(0, 2) != 0);
        r.ia = 32'($urandom_range(0, 63));
      end
      if (!d_hold) begin
        r.dv = ($urandom_range(0, 3) != 0);
        r.da = 32'($urandom_range(0, 63));
        r.we = ($urandom_range(0, 2) == 0);
        r.wd = $urandom;
      end
      run_cycle(r, 1'b0, gi, gd);
      i_hold = r.iv && !gi && !r.rst;
      d_hold = r.dv && !gd && !r.rst;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
